// File: rtl/turbo_pkg.sv
// Shared types and constants for the turbo-decoder survivor-path sequencer.
// Metrics are 16-bit sign-magnitude, with 100 representing 1.0.
package turbo_pkg;

  localparam int SM_W       = 16;
  localparam int SIGN_BIT   = 15;
  localparam int MAG_MSB    = 14;
  localparam int MAG_W      = 15;
  localparam int N_METRIC   = 8;
  localparam int METRIC_ONE = 100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_TAIL  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/sm_norm.sv
// Normalises one sign-magnitude branch metric: clamps the magnitude to MAX_MAG
// and folds negative zero onto positive zero.
module sm_norm
  import turbo_pkg::*;
#(
  parameter logic [MAG_W-1:0] MAX_MAG = MAG_W'(4*METRIC_ONE)
) (
  input  logic [SM_W-1:0] metric_i,
  output logic [SM_W-1:0] metric_o
);

  logic [MAG_W-1:0] mag;

  assign mag = metric_i[MAG_MSB:0];

  always_comb begin
    metric_o = metric_i;
    if (mag == '0) begin
      metric_o = '0;
    end else if (mag > MAX_MAG) begin
      metric_o = {metric_i[SIGN_BIT], MAX_MAG};
    end
  end

endmodule

// File: rtl/survive_seq.sv
// Frame sequencer for the survivor-path datapath: feeds normalised branch
// metrics plus tail steps, and tags the datapath outputs with step indices.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | one-cycle state-metric initialise (dp_clr)
// RUN     | accepting K metric beats
// TAIL    | issuing TAIL_LEN zero-metric termination steps
// DRAIN   | waiting for the latency pipeline to empty
// DONE    | one-cycle frame-complete pulse
module survive_seq
  import turbo_pkg::*;
#(
  parameter int               K_W      = 12,
  parameter int               TAIL_LEN = 3,
  parameter int               DP_LAT   = 2,
  parameter logic [MAG_W-1:0] MAX_MAG  = MAG_W'(4*METRIC_ONE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [K_W-1:0]        cfg_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_METRIC*SM_W-1:0] in_metric,
  output logic                  dp_clr,
  output logic                  dp_en,
  output logic [SM_W-1:0]       dp_m11,
  output logic [SM_W-1:0]       dp_m21,
  output logic [SM_W-1:0]       dp_m31,
  output logic [SM_W-1:0]       dp_m41,
  output logic [SM_W-1:0]       dp_m12,
  output logic [SM_W-1:0]       dp_m22,
  output logic [SM_W-1:0]       dp_m32,
  output logic [SM_W-1:0]       dp_m42,
  output logic                  sv_valid,
  output logic [K_W-1:0]        sv_step,
  output logic                  sv_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  err_len
);

  localparam logic [K_W-1:0] ONE_K     = K_W'(1);
  localparam logic [K_W-1:0] TAIL_LAST = K_W'(TAIL_LEN - 1);

  seq_state_e state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic [K_W-1:0] step_q, step_d;
  logic [K_W-1:0] dp_step_q, dp_step_d;
  logic           dp_en_q, dp_en_d;
  logic           dp_tail_q, dp_tail_d;
  logic           err_q, err_d;
  logic           pending;

  logic [N_METRIC-1:0][SM_W-1:0] norm;
  logic [N_METRIC-1:0][SM_W-1:0] dp_m_q, dp_m_d;

  logic [DP_LAT-1:0]          pipe_en_q;
  logic [DP_LAT-1:0]          pipe_tail_q;
  logic [DP_LAT-1:0][K_W-1:0] pipe_step_q;

  for (genvar g = 0; g < N_METRIC; g++) begin : g_norm
    sm_norm #(.MAX_MAG(MAX_MAG)) u_norm (
      .metric_i(in_metric[g*SM_W +: SM_W]),
      .metric_o(norm[g])
    );
  end

  assign in_ready = (state_q == S_RUN);
  assign pending  = dp_en_q || (|pipe_en_q);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    step_d    = step_q;
    dp_en_d   = 1'b0;
    dp_tail_d = 1'b0;
    dp_m_d    = '0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            k_d     = cfg_len;
            step_d  = '0;
            state_d = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (in_valid) begin
          dp_en_d = 1'b1;
          dp_m_d  = norm;
          step_d  = step_q + ONE_K;
          if (step_q == k_q - ONE_K) state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        dp_en_d   = 1'b1;
        dp_tail_d = 1'b1;
        step_d    = step_q + ONE_K;
        if (step_q == k_q + TAIL_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!pending) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort wins over everything, including a start sampled in IDLE
    if (abort) begin
      state_d   = S_IDLE;
      dp_en_d   = 1'b0;
      dp_tail_d = 1'b0;
      dp_m_d    = '0;
      err_d     = 1'b0;
    end
    dp_step_d = dp_en_d ? step_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      step_q      <= '0;
      dp_step_q   <= '0;
      dp_en_q     <= 1'b0;
      dp_tail_q   <= 1'b0;
      dp_m_q      <= '0;
      err_q       <= 1'b0;
      pipe_en_q   <= '0;
      pipe_tail_q <= '0;
      pipe_step_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      step_q    <= step_d;
      dp_step_q <= dp_step_d;
      dp_en_q   <= dp_en_d;
      dp_tail_q <= dp_tail_d;
      dp_m_q    <= dp_m_d;
      err_q     <= err_d;
      if (abort) begin
        pipe_en_q   <= '0;
        pipe_tail_q <= '0;
        pipe_step_q <= '0;
      end else begin
        for (int i = DP_LAT - 1; i > 0; i--) begin
          pipe_en_q[i]   <= pipe_en_q[i-1];
          pipe_tail_q[i] <= pipe_tail_q[i-1];
          pipe_step_q[i] <= pipe_step_q[i-1];
        end
        pipe_en_q[0]   <= dp_en_q;
        pipe_tail_q[0] <= dp_tail_q;
        pipe_step_q[0] <= dp_step_q;
      end
    end
  end

  assign dp_clr   = (state_q == S_CLEAR);
  assign dp_en    = dp_en_q;
  assign dp_m11   = dp_m_q[0];
  assign dp_m21   = dp_m_q[1];
  assign dp_m31   = dp_m_q[2];
  assign dp_m41   = dp_m_q[3];
  assign dp_m12   = dp_m_q[4];
  assign dp_m22   = dp_m_q[5];
  assign dp_m32   = dp_m_q[6];
  assign dp_m42   = dp_m_q[7];
  assign sv_valid = pipe_en_q[DP_LAT-1];
  assign sv_step  = pipe_step_q[DP_LAT-1];
  assign sv_tail  = pipe_tail_q[DP_LAT-1];
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err_len  = err_q;

endmodule

// File: tb/tb_survive_seq.sv
// Self-checking bench for survive_seq: frame-level reference model built from
// the sequencing rules, compared against logged datapath and survivor events.
module tb_survive_seq;

  localparam int K_W      = 12;
  localparam int TAIL_LEN = 3;
  localparam int DP_LAT   = 2;

  logic           clk = 1'b0;
  logic           rst, start, abort, in_valid, in_ready;
  logic [K_W-1:0] cfg_len, sv_step;
  logic [127:0]   in_metric, dp_all;
  logic           dp_clr, dp_en, sv_valid, sv_tail, busy, done, err_len;
  logic [15:0]    dp_m11, dp_m21, dp_m31, dp_m41, dp_m12, dp_m22, dp_m32, dp_m42;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int clr_cnt, err_cnt, busy_cnt;
  int dp_cyc_q[$], sv_cyc_q[$], sv_step_q[$], done_cyc_q[$];
  bit sv_tail_q[$];
  logic [127:0] dp_val_q[$], beat_q[$];
  bit use_fixed = 1'b0;
  logic [127:0] fixed_metric = '0;

  always #5 clk = ~clk;

  survive_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_metric(in_metric),
    .dp_clr(dp_clr), .dp_en(dp_en),
    .dp_m11(dp_m11), .dp_m21(dp_m21), .dp_m31(dp_m31), .dp_m41(dp_m41),
    .dp_m12(dp_m12), .dp_m22(dp_m22), .dp_m32(dp_m32), .dp_m42(dp_m42),
    .sv_valid(sv_valid), .sv_step(sv_step), .sv_tail(sv_tail),
    .busy(busy), .done(done), .err_len(err_len)
  );

  assign dp_all = {dp_m42, dp_m32, dp_m22, dp_m12, dp_m41, dp_m31, dp_m21, dp_m11};

  always @(negedge clk) begin
    if (dp_en) begin
      dp_cyc_q.push_back(cyc);
      dp_val_q.push_back(dp_all);
    end
    if (sv_valid) begin
      sv_cyc_q.push_back(cyc);
      sv_step_q.push_back(int'(sv_step));
      sv_tail_q.push_back(sv_tail);
    end
    if (done) done_cyc_q.push_back(cyc);
    if (dp_clr) clr_cnt++;
    if (err_len) err_cnt++;
    if (busy) busy_cnt++;
    cyc++;
  end

  // Reference normalisation: clamp |x| to 4.0 (400), keep sign, -0 becomes +0
  function automatic logic [127:0] model_norm(input logic [127:0] v);
    logic [127:0] r;
    int mag, sgn;
    r = '0;
    for (int f = 0; f < 8; f++) begin
      mag = int'(v[f*16 +: 15]);
      sgn = int'(v[f*16 + 15]);
      if (mag == 0)        r[f*16 +: 16] = 16'h0000;
      else if (mag > 400)  r[f*16 +: 16] = 16'(sgn * 32768 + 400);
      else                 r[f*16 +: 16] = 16'(sgn * 32768 + mag);
    end
    return r;
  endfunction

  function automatic logic [127:0] rand_metric();
    logic [127:0] r;
    int mag;
    r = '0;
    for (int f = 0; f < 8; f++) begin
      case ($urandom_range(0, 4))
        0:       mag = 0;
        1:       mag = $urandom_range(1, 399);
        2:       mag = 400;
        3:       mag = 401;
        default: mag = $urandom_range(402, 32767);
      endcase
      r[f*16 +: 16] = 16'(int'($urandom_range(0, 1)) * 32768 + mag);
    end
    return r;
  endfunction

  task automatic clear_logs();
    dp_cyc_q.delete(); dp_val_q.delete();
    sv_cyc_q.delete(); sv_step_q.delete(); sv_tail_q.delete();
    done_cyc_q.delete(); beat_q.delete();
    clr_cnt = 0; err_cnt = 0; busy_cnt = 0;
  endtask

  task automatic start_frame(input int k);
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1; cfg_len = K_W'(k);
    @(posedge clk); #1;
    start = 1'b0; cfg_len = K_W'($urandom_range(0, 15));
  endtask

  // mode 0: always valid, 1: random valid, 2: 1,0,1,1,0,1 then always valid
  task automatic drive_beats(input int n, input int mode, input bit chk_drop);
    int sent = 0;
    int idx = 0;
    bit v;
    bit pat[6];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    while (sent < n && idx < 500) begin
      @(posedge clk); #1;
      case (mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 9) < 7);
        default: v = (idx < 6) ? pat[idx] : 1'b1;
      endcase
      idx++;
      in_valid  = v;
      in_metric = use_fixed ? fixed_metric : rand_metric();
      @(negedge clk);
      if (v && in_ready) begin
        beat_q.push_back(in_metric);
        sent++;
      end
    end
    checks++;
    if (sent < n) begin
      errors++;
      $display("FAIL beats_accepted: got %0d want %0d", sent, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (chk_drop) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL in_ready_drop: got %b want 0", in_ready);
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int i = 0;
    while (done_cyc_q.size() == 0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (done_cyc_q.size() == 0) begin
      errors++;
      $display("FAIL %s done_timeout: got no done within %0d cycles", tag, i);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input int k, input string tag);
    int n = k + TAIL_LEN;
    logic [127:0] exp;
    checks++;
    if (dp_cyc_q.size() != n) begin
      errors++;
      $display("FAIL %s dp_en_count: got %0d want %0d", tag, dp_cyc_q.size(), n);
    end
    for (int i = 0; i < n && i < dp_val_q.size(); i++) begin
      exp = (i < k && i < beat_q.size()) ? model_norm(beat_q[i]) : '0;
      checks++;
      if (dp_val_q[i] !== exp) begin
        errors++;
        $display("FAIL %s dp_metrics[%0d]: got %h want %h", tag, i, dp_val_q[i], exp);
      end
    end
    checks++;
    if (sv_cyc_q.size() != n) begin
      errors++;
      $display("FAIL %s sv_valid_count: got %0d want %0d", tag, sv_cyc_q.size(), n);
    end
    for (int i = 0; i < n && i < sv_cyc_q.size(); i++) begin
      checks++;
      if (sv_step_q[i] != i || sv_tail_q[i] != (i >= k)) begin
        errors++;
        $display("FAIL %s sv_tag[%0d]: got step %0d tail %0d want step %0d tail %0d",
                 tag, i, sv_step_q[i], sv_tail_q[i], i, (i >= k));
      end
      if (i < dp_cyc_q.size()) begin
        checks++;
        if (sv_cyc_q[i] - dp_cyc_q[i] != DP_LAT) begin
          errors++;
          $display("FAIL %s sv_latency[%0d]: got %0d want %0d", tag, i,
                   sv_cyc_q[i] - dp_cyc_q[i], DP_LAT);
        end
      end
    end
    checks++;
    if (done_cyc_q.size() != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d want 1", tag, done_cyc_q.size());
    end else if (sv_cyc_q.size() > 0) begin
      checks++;
      if (done_cyc_q[0] <= sv_cyc_q[sv_cyc_q.size()-1]) begin
        errors++;
        $display("FAIL %s done_order: got cycle %0d want after %0d", tag,
                 done_cyc_q[0], sv_cyc_q[sv_cyc_q.size()-1]);
      end
    end
    checks++;
    if (clr_cnt != 1) begin
      errors++;
      $display("FAIL %s dp_clr_count: got %0d want 1", tag, clr_cnt);
    end
  endtask

  task automatic run_frame(input int k, input int mode, input string tag);
    start_frame(k);
    drive_beats(k, mode, 1'b1);
    wait_done(tag);
    check_frame(k, tag);
  endtask

  task automatic check_all_zero(input string tag);
    logic [200:0] obs;
    obs = {dp_clr, dp_en, sv_valid, sv_tail, busy, done, err_len, in_ready, sv_step, dp_all};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL %s outputs_zero: got %h want 0", tag, obs);
    end
  endtask

  task automatic test_reset();
    #12;
    check_all_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_released");
  endtask

  task automatic test_single_beat();
    logic [15:0] f;
    use_fixed = 1'b1;
    fixed_metric = '0;
    fixed_metric[15:0]  = 16'h801E;
    fixed_metric[31:16] = 16'h0064;
    fixed_metric[79:64] = 16'h8064;
    fixed_metric[95:80] = 16'h8032;
    run_frame(1, 0, "single_beat");
    f = (dp_val_q.size() > 0) ? dp_val_q[0][15:0] : 16'hxxxx;
    checks++;
    if (f !== 16'h801E) begin
      errors++;
      $display("FAIL single_beat dp_m11: got %h want 801e", f);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_clamp_zero();
    logic [127:0] v;
    use_fixed = 1'b1;
    fixed_metric = '0;
    fixed_metric[15:0]  = 16'h0190;
    fixed_metric[31:16] = 16'h01F4;
    fixed_metric[47:32] = 16'h81F4;
    fixed_metric[63:48] = 16'h8000;
    fixed_metric[79:64] = 16'h8191;
    run_frame(1, 0, "clamp_zero");
    v = (dp_val_q.size() > 0) ? dp_val_q[0] : '1;
    checks++;
    if (v[31:16] !== 16'h0190) begin
      errors++; $display("FAIL clamp dp_m21: got %h want 0190", v[31:16]);
    end
    checks++;
    if (v[47:32] !== 16'h8190) begin
      errors++; $display("FAIL clamp dp_m31: got %h want 8190", v[47:32]);
    end
    checks++;
    if (v[63:48] !== 16'h0000) begin
      errors++; $display("FAIL negzero dp_m41: got %h want 0000", v[63:48]);
    end
    checks++;
    if (v[79:64] !== 16'h8190 || v[15:0] !== 16'h0190) begin
      errors++; $display("FAIL clamp_edge m12/m11: got %h/%h want 8190/0190", v[79:64], v[15:0]);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_backpressure();
    run_frame(4, 2, "backpressure");
  endtask

  task automatic test_back_to_back();
    int n = 5 + TAIL_LEN;
    run_frame(5, 0, "back_to_back");
    if (dp_cyc_q.size() == n) begin
      checks++;
      if (dp_cyc_q[n-1] - dp_cyc_q[0] != n - 1) begin
        errors++;
        $display("FAIL back_to_back dp_en_span: got %0d want %0d", dp_cyc_q[n-1] - dp_cyc_q[0], n - 1);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) run_frame($urandom_range(1, 6), 1, "random");
  endtask

  task automatic test_zero_length();
    start_frame(0);
    repeat (4) @(negedge clk);
    checks++;
    if (err_cnt != 1 || busy_cnt != 0 || clr_cnt != 0) begin
      errors++;
      $display("FAIL zero_length: got err %0d busy %0d clr %0d want 1 0 0", err_cnt, busy_cnt, clr_cnt);
    end
  endtask

  task automatic test_abort();
    start_frame(8);
    drive_beats(3, 0, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    clear_logs();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_busy: got %b want 0", busy);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (dp_cyc_q.size() != 0 || sv_cyc_q.size() != 0 || done_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL abort_flush: got dp_en %0d sv_valid %0d done %0d want 0 0 0",
               dp_cyc_q.size(), sv_cyc_q.size(), done_cyc_q.size());
    end
    run_frame(3, 1, "after_abort");
  endtask

  task automatic test_async_reset();
    use_fixed = 1'b1;
    fixed_metric = {8{16'h0123}};
    start_frame(2);
    drive_beats(2, 0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    use_fixed = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_frame(3, 1, "after_reset");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    cfg_len = '0; in_metric = '0;
    test_reset();
    test_single_beat();
    test_clamp_zero();
    test_backpressure();
    test_back_to_back();
    test_random_frames();
    test_zero_length();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/survive_seq.md
Name: survive_seq

Overview:
- Frame sequencer for the turbo-decoder survivor-path datapath (`survive`).
- Accepts per-trellis-step branch-metric beats (eight 16-bit sign-magnitude metrics m11..m42) through a valid/ready handshake.
- Normalises the metrics and drives them into the datapath with clear/enable strobes, then appends termination (tail) steps.
- Tracks datapath latency, tags each survivor-vector output with its step index, and signals frame completion.

Parameters:
- K_W, 12, width of frame-length config and step counter.
- TAIL_LEN, 3, number of termination steps appended after K data steps.
- DP_LAT, 2, cycles from dp_en to valid v_1..v_14 at the datapath output (must be ≥1).
- MAX_MAG, 15'd400, magnitude clamp for metrics (scale 100 = 1.0, so 4.0).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin frame; sampled only in IDLE
- abort  in  1  synchronous abort, any state
- cfg_len  in  K_W  frame length K in steps; latched on accepted start
- in_valid  in  1  metric beat valid
- in_ready  out  1  sequencer accepts beat
- in_metric  in  128  {m42,m32,m22,m12,m41,m31,m21,m11}, 16 bits each: bit15 = sign, [14:0] = magnitude
- dp_clr  out  1  one-cycle state-metric initialise to datapath
- dp_en  out  1  datapath step enable
- dp_m11,dp_m21,dp_m31,dp_m41,dp_m12,dp_m22,dp_m32,dp_m42  out  16 each  registered metrics to datapath
- sv_valid  out  1  datapath outputs v_1..v_14 valid this cycle
- sv_step  out  K_W  step index of the current sv_valid
- sv_tail  out  1  current sv_valid belongs to a tail step
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle frame-complete pulse
- err_len  out  1  one-cycle pulse: start with cfg_len = 0

Behaviour:
- **Reset:** all outputs 0, all dp_m* = 16'h0000, state = IDLE, counters and latency pipeline cleared.
- **FSM:** IDLE → CLEAR → RUN → TAIL → DRAIN → DONE → IDLE.
- **IDLE:**
  - start with cfg_len ≠ 0: latch K, step_cnt = 0, go to CLEAR.
  - start with cfg_len = 0: err_len pulses the next cycle; stay in IDLE.
- **CLEAR:** dp_clr = 1 for exactly one cycle; go to RUN.
- **RUN:**
  - in_ready = 1.
  - Beat accepted when in_valid && in_ready.
  - On the cycle after acceptance: dp_en = 1, dp_m* hold the normalised metrics, step_cnt increments.
  - After the K-th accepted beat: in_ready drops the next cycle, go to TAIL.
  - No bubbles are inserted, so back-to-back beats give dp_en high continuously.
- **TAIL:**
  - dp_en = 1 for TAIL_LEN consecutive cycles with all dp_m* = 16'h0000.
  - Steps are indexed K .. K+TAIL_LEN−1 and marked as tail.
- **DRAIN:** wait until the latency pipeline is empty (the last sv_valid has been emitted); go to DONE.
- **DONE:** done = 1 for one cycle; return to IDLE.
- **Latency pipeline:** a DP_LAT-deep shift register of {en, step, tail}. sv_valid, sv_step and sv_tail are exactly the dp_en, step and tail values from DP_LAT cycles earlier.
- **Metric normalisation** (per field, registered, one cycle):
  - magnitude > MAX_MAG → magnitude = MAX_MAG, sign kept;
  - magnitude == 0 → output 16'h0000 (negative zero removed);
  - otherwise unchanged.
- **abort:**
  - Next state IDLE; dp_en and dp_clr forced to 0 from the next cycle.
  - Latency pipeline flushed, so no further sv_valid.
  - No done pulse.
  - abort takes priority over start in the same cycle.
- start while busy: ignored.
- in_valid outside RUN: not accepted; in_ready = 0.
- **Counter width:** step_cnt must reach K+TAIL_LEN−1 without wrap; cfg_len > 2^K_W−1−TAIL_LEN is unsupported.
- **rst mid-frame:** immediate return to reset values; the asynchronous assert overrides everything.

Decomposition:
- Shared package (turbo_pkg):
  - SM_W = 16 and the sign-magnitude field positions;
  - METRIC_ONE = 100;
  - state enumeration for survive_seq.
- One sub-module: sm_norm, a combinational clamp plus negative-zero removal for a single 16-bit sign-magnitude field, instantiated 8 times.

Test Plan:
- **Single-beat frame:** K = 1; one beat with m11 = 16'h801E (−0.3), m12 = 16'h8064, m21 = 16'h0064, m22 = 16'h8032. Required: dp_clr 1 cycle; then dp_en with dp_m11 = 16'h801E; 3 tail dp_en with zeros; sv_valid 4 times with sv_step 0,1,2,3 and sv_tail = 0,1,1,1, each DP_LAT = 2 cycles after its dp_en; done once.
- **Clamp and zero:** m21 = 16'h01F4 (5.0) → dp_m21 = 16'h0190; m31 = 16'h81F4 → 16'h8190; m41 = 16'h8000 → 16'h0000.
- **Backpressure gaps:** K = 4 with in_valid toggling 1,0,1,1,0,1 → exactly 4 data dp_en, steps 0..3 in order; in_ready low immediately after the 4th beat.
- **Zero length:** start with cfg_len = 0 → err_len pulse; busy stays 0; no dp_clr.
- **Abort mid-RUN:** K = 8, abort after 3 beats → no further dp_en or sv_valid after the flush, no done, busy = 0 next cycle; a new start then runs normally.
- **Async reset mid-TAIL:** assert rst between clock edges → all outputs 0 immediately; after release, a subsequent frame completes correctly.
